// File: rtl/rotl_seq_8bit_if.sv
// Handshake bundle for rotl_seq_8bit: operand/amount in, rotated result out.
// master = producer/consumer side, slave = the rotate engine.
interface rotl_seq_8bit_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [2:0] amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       busy;

    modport master (
        output in_valid, a, amt, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, a, amt, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/rotl_seq_8bit.sv
// Sequential 8-bit rotate-left engine: one bit per clock, valid/ready on both sides.
// Define ROTL_FAST_EN to load the fully rotated operand on the accept edge instead.
module rotl_seq_8bit #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    rotl_seq_8bit_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] y_r;

`ifdef ROTL_FAST_EN
    // Single-step rotate: upper half of the doubled operand shifted left.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v,
                                              input logic [2:0]       k);
        logic [2*WIDTH-1:0] d;
        d = {v, v} << k;
        return d[2*WIDTH-1:WIDTH];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            y_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        y_r   <= rotl(bus.a, bus.amt);
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    logic [2:0] cnt;

    // cnt holds the remaining steps; the cnt==0 cycle spends one edge moving to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            y_r   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        y_r   <= bus.a;
                        cnt   <= bus.amt;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt == 3'd0) begin
                        state <= S_DONE;
                    end else begin
                        y_r <= {y_r[WIDTH-2:0], y_r[WIDTH-1]};
                        cnt <= cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`endif

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.y         = y_r;
endmodule

// File: tb/tb_rotl_seq_8bit.sv
// Self-checking bench for rotl_seq_8bit: reset, directed vector table, mid-op reset,
// and randomized operations against an arithmetic rotate model.
module tb_rotl_seq_8bit;
    logic clk = 1'b0;
    logic rst;

`ifdef ROTL_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    rotl_seq_8bit_if bus();

    rotl_seq_8bit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] a;
        logic [2:0] amt;
        int         hold;
        logic [7:0] exp_y;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rotl_ref(input int v, input int k);
        return ((v << k) | (v >> (8 - k))) & 255;
    endfunction

    function automatic int rotr_ref(input int v, input int k);
        return ((v >> k) | (v << (8 - k))) & 255;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; called 1 ns after an edge with the engine idle.
    task automatic run_op(input logic [7:0] a, input logic [2:0] amt, input int hold,
                          input int exp_y, input bit rnd_noise);
        int lat;
        int exp_lat;
        // Iterative: out_valid rises amt+1 edges after accept. Fast: already on the accept edge.
        exp_lat = FAST ? 0 : int'(amt) + 1;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.amt      = amt;
        check("in_ready_before_accept", int'(bus.in_ready), 1);
        tick();
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            check("in_ready_while_shift", int'(bus.in_ready), 0);
            check("busy_while_shift", int'(bus.busy), 1);
            bus.in_valid  = rnd_noise ? 1'($urandom) : 1'b0;
            bus.a         = 8'($urandom);
            bus.amt       = 3'($urandom);
            bus.out_ready = rnd_noise ? 1'($urandom) : 1'b0;
            tick();
            lat++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = rnd_noise ? 1'($urandom) : 1'b0;
        check("latency", lat, exp_lat);
        check("out_valid", int'(bus.out_valid), 1);
        check("y_result", int'(bus.y), exp_y);
        check("rotr_undo", rotr_ref(int'(bus.y), int'(amt)), int'(a));
        check("busy_done", int'(bus.busy), 1);
        for (int i = 0; i < hold; i++) begin
            tick();
            bus.a = 8'($urandom);
            check("hold_out_valid", int'(bus.out_valid), 1);
            check("hold_y", int'(bus.y), exp_y);
            check("hold_in_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("release_out_valid", int'(bus.out_valid), 0);
        check("release_in_ready", int'(bus.in_ready), 1);
        check("release_busy", int'(bus.busy), 0);
    endtask

    initial begin
        int seen;
        logic [7:0] ra;
        logic [2:0] rk;

        tbl[0] = '{a: 8'hA5, amt: 3'd3, hold: 0, exp_y: 8'h2D};
        tbl[1] = '{a: 8'h3C, amt: 3'd0, hold: 0, exp_y: 8'h3C};
        tbl[2] = '{a: 8'h01, amt: 3'd7, hold: 0, exp_y: 8'h80};
        tbl[3] = '{a: 8'h81, amt: 3'd1, hold: 5, exp_y: 8'h03};
        tbl[4] = '{a: 8'hFF, amt: 3'd5, hold: 1, exp_y: 8'hFF};
        tbl[5] = '{a: 8'h80, amt: 3'd1, hold: 2, exp_y: 8'h01};

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 8'h5A;
        bus.amt       = 3'd2;
        bus.out_ready = 1'b0;

        // Reset held with in_valid asserted: nothing may be accepted.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_in_ready", int'(bus.in_ready), 1);
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_y", int'(bus.y), 0);
            check("rst_busy", int'(bus.busy), 0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("post_rst_idle", int'(bus.busy), 0);

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].a, tbl[i].amt, tbl[i].hold, int'(tbl[i].exp_y), 1'b0);

        // Reset during the second SHIFT cycle aborts the operation.
        bus.in_valid = 1'b1;
        bus.a        = 8'hF0;
        bus.amt      = 3'd6;
        tick();
        bus.in_valid = 1'b0;
        seen = int'(bus.out_valid);
        tick();
        seen += int'(bus.out_valid);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_pre_out_valid", seen, FAST ? 2 : 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        check("midrst_y", int'(bus.y), 0);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen += int'(bus.out_valid);
        end
        check("midrst_no_pulse", seen, 0);

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rk = 3'($urandom);
            run_op(ra, rk, int'($urandom_range(0, 3)), rotl_ref(int'(ra), int'(rk)), 1'b1);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
